// File: rtl/link_tx_pkg.sv
// link_tx_pkg: shared sizing constants and state encoding for the link
// transmitter and its credit counter.
//   PAYLOAD_SIZE / ADDR_BITS : flit field widths (flit = payload + address)
//   FIFO_LOG2                : log2 of the downstream fifo depth
//   FIFO_DEPTH_LOG2          : width base for credit counts (count is +1 wide)
//   FIFO_DEPTH               : downstream fifo depth, default credit budget
package link_tx_pkg;
   localparam int PAYLOAD_SIZE    = 4;
   localparam int ADDR_BITS       = 4;
   localparam int FLIT_W          = PAYLOAD_SIZE + ADDR_BITS;
   localparam int FIFO_LOG2       = 2;
   localparam int FIFO_DEPTH_LOG2 = FIFO_LOG2;
   localparam int FIFO_DEPTH      = 1 << FIFO_LOG2;
   localparam int CREDIT_W        = FIFO_DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      BLOCKED = 2'd2
   } tx_state_t;
endpackage

// File: rtl/link_tx_credit_counter.sv
// credit_counter: up/down saturating counter of free downstream slots.
//   clk, reset : clock, asynchronous active-low reset (count reloads to MAX)
//   inc        : one slot freed downstream
//   dec        : one flit sent (caller only asserts while nonzero)
//   count      : current credit count
//   nonzero    : count != 0
//   overflow   : inc with no dec while already at MAX (count saturates)
module credit_counter
   import link_tx_pkg::*;
#(
   parameter int MAX = FIFO_DEPTH,
   parameter int W   = CREDIT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         nonzero,
   output logic         overflow
);
   localparam logic [W-1:0] MAX_W = W'(MAX);

   logic [W-1:0] count_nxt;

   assign nonzero  = (count != '0);
   assign overflow = inc & ~dec & (count == MAX_W);

   always_comb begin
      count_nxt = count;
      unique case ({inc, dec})
         2'b10:   if (count != MAX_W) count_nxt = count + 1'b1;
         2'b01:   if (nonzero)        count_nxt = count - 1'b1;
         default: count_nxt = count;  // idle, or inc and dec cancel out
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) count <= MAX_W;
      else        count <= count_nxt;
   end
endmodule

// File: rtl/link_tx.sv
// link_tx: credit-based transmitter for one router output port. Pops the
// local output fifo one flit per cycle while downstream credits remain and
// registers each popped flit onto the link.
//   clk, reset  : clock, asynchronous active-low reset
//   tx_en       : allow popping; when low, the flit in the output reg drains
//   fifo_empty  : local fifo empty
//   fifo_item   : local fifo head (combinational at read pointer)
//   fifo_read   : combinational pop strobe to the local fifo
//   tx_valid    : registered flit valid on the link
//   tx_data     : registered flit on the link
//   credit_in   : one-cycle pulse, one downstream slot freed
//   credits     : current credit count
//   blocked     : state is BLOCKED (data waiting, no credits)
//   credit_err  : sticky credit overflow flag, cleared only by reset
module link_tx
   import link_tx_pkg::*;
#(
   parameter int ROUTERID = -1,
   parameter int CREDITS  = FIFO_DEPTH
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tx_en,
   input  logic                fifo_empty,
   input  logic [FLIT_W-1:0]   fifo_item,
   output logic                fifo_read,
   output logic                tx_valid,
   output logic [FLIT_W-1:0]   tx_data,
   input  logic                credit_in,
   output logic [CREDIT_W-1:0] credits,
   output logic                blocked,
   output logic                credit_err
);
   // Debug-only router index; kept visible for waveform inspection.
   logic [31:0] unused_router_id;
   assign unused_router_id = ROUTERID;

   tx_state_t state, state_nxt;
   logic      nonzero;
   logic      overflow;
   logic      pending;
   logic      pop;

   // Credit gating uses the registered count, so a credit returned in
   // cycle N is first spendable in cycle N+1. Gating with reset keeps the
   // fifo from being drained while the link is held in reset.
   assign pending   = tx_en & ~fifo_empty;
   assign pop       = reset & pending & nonzero;
   assign fifo_read = pop;
   assign blocked   = (state == BLOCKED);

   credit_counter #(
      .MAX (CREDITS),
      .W   (CREDIT_W)
   ) u_credits (
      .clk      (clk),
      .reset    (reset),
      .inc      (credit_in),
      .dec      (pop),
      .count    (credits),
      .nonzero  (nonzero),
      .overflow (overflow)
   );

   // Every state shares the same exits: a pop means ACTIVE, data waiting
   // without a pop can only mean zero credits (BLOCKED), else IDLE.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, ACTIVE, BLOCKED: begin
            if (pop)          state_nxt = ACTIVE;
            else if (pending) state_nxt = BLOCKED;
            else              state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         tx_valid   <= 1'b0;
         tx_data    <= '0;
         credit_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         tx_valid <= pop;
         if (pop)      tx_data    <= fifo_item;
         if (overflow) credit_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_link_tx.sv
// tb_link_tx: directed bench for link_tx with a behavioural local fifo and
// an in-order scoreboard of flits expected on the link.
module tb_link_tx;
   import link_tx_pkg::*;

   logic                clk = 1'b0;
   logic                reset;
   logic                tx_en;
   logic                fifo_empty;
   logic [FLIT_W-1:0]   fifo_item;
   logic                fifo_read;
   logic                tx_valid;
   logic [FLIT_W-1:0]   tx_data;
   logic                credit_in;
   logic [CREDIT_W-1:0] credits;
   logic                blocked;
   logic                credit_err;

   int errors = 0;
   int checks = 0;

   logic [FLIT_W-1:0] mem [0:63];
   int wr_ptr = 0;
   int rd_ptr = 0;
   logic [FLIT_W-1:0] exp_q [$];

   always #5 clk = ~clk;

   link_tx #(.ROUTERID(3), .CREDITS(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .tx_en      (tx_en),
      .fifo_empty (fifo_empty),
      .fifo_item  (fifo_item),
      .fifo_read  (fifo_read),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .credit_in  (credit_in),
      .credits    (credits),
      .blocked    (blocked),
      .credit_err (credit_err)
   );

   assign fifo_empty = (rd_ptr == wr_ptr);
   assign fifo_item  = mem[rd_ptr[5:0]];

   always @(posedge clk) if (fifo_read) rd_ptr <= rd_ptr + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [FLIT_W-1:0] d);
      mem[wr_ptr[5:0]] = d;
      wr_ptr++;
      exp_q.push_back(d);
   endtask

   // Link monitor: every valid flit must match the oldest outstanding push.
   always @(negedge clk) begin
      if (reset && tx_valid) begin
         if (exp_q.size() == 0) check("spurious_flit", {24'h0, tx_data}, 32'hFFFF_FFFF);
         else                   check("sb_flit", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
   end

   initial begin
      logic [FLIT_W-1:0] stream [4];
      stream = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 64; i++) mem[i] = '0;
      reset = 1'b0; tx_en = 1'b0; credit_in = 1'b0;

      // Reset state
      #12;
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_credits", credits, 4);
      check("rst_credit_err", credit_err, 0);
      check("rst_blocked", blocked, 0);
      check("rst_fifo_read", fifo_read, 0);
      tick(); reset = 1'b1; tick();

      // Streaming: 4 credits, 5 flits queued
      for (int i = 0; i < 4; i++) push(stream[i]);
      push(8'h55);
      tx_en = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("stream_read", fifo_read, 1);
         tick();
         check("stream_valid", tx_valid, 1);
         check("stream_data", tx_data, stream[i]);
         check("stream_credits", credits, 32'(3 - i));
      end
      check("exhaust_read", fifo_read, 0);
      tick();
      check("exhaust_blocked", blocked, 1);
      check("exhaust_valid", tx_valid, 0);
      check("exhaust_credits", credits, 0);
      check("exhaust_pending", fifo_empty, 0);

      // Credit recovery
      credit_in = 1'b1; tick(); credit_in = 1'b0; #1;
      check("recov_credits", credits, 1);
      check("recov_read", fifo_read, 1);
      tick();
      check("recov_valid", tx_valid, 1);
      check("recov_data", tx_data, 8'h55);
      check("recov_credits0", credits, 0);
      tick();
      check("recov_idle", blocked, 0);
      check("recov_valid0", tx_valid, 0);

      // Simultaneous pop and credit return at credits == 2
      credit_in = 1'b1; tick(); tick();
      check("sim_pre", credits, 2);
      for (int i = 0; i < 10; i++) push(FLIT_W'(8'hA0 + i));
      #1;
      check("sim_read", fifo_read, 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("sim_credits", credits, 2);
      end
      credit_in = 1'b0;
      check("sim_drained", fifo_empty, 1);

      // Overflow
      credit_in = 1'b1; tick(); tick(); credit_in = 1'b0; #1;
      check("ovf_full", credits, 4);
      check("ovf_err0", credit_err, 0);
      credit_in = 1'b1; tick(); credit_in = 1'b0; #1;
      check("ovf_sat", credits, 4);
      check("ovf_err", credit_err, 1);
      tick(); tick();
      check("ovf_sticky", credit_err, 1);

      // Enable gating
      for (int i = 0; i < 6; i++) push(FLIT_W'(8'hC0 + i));
      tick(); tick();
      tx_en = 1'b0; #1;
      check("gate_read", fifo_read, 0);
      check("gate_last_valid", tx_valid, 1);
      check("gate_last_data", tx_data, 8'hC1);
      tick();
      check("gate_valid0", tx_valid, 0);
      check("gate_read0", fifo_read, 0);
      check("gate_idle", blocked, 0);
      check("gate_credits", credits, 2);
      check("gate_remaining", exp_q.size(), 4);

      // Reset mid-stream with 3 flits left in the fifo
      tx_en = 1'b1; tick();
      reset = 1'b0; #1;
      check("midrst_left", wr_ptr - rd_ptr, 3);
      check("midrst_valid", tx_valid, 0);
      check("midrst_credits", credits, 4);
      check("midrst_read", fifo_read, 0);
      check("midrst_err", credit_err, 0);
      exp_q.delete();
      wr_ptr = rd_ptr;
      tick(); tick();
      reset = 1'b1;
      tick();
      check("post_rst_credits", credits, 4);
      check("post_rst_valid", tx_valid, 0);
      tick();
      check("sb_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      checks++;
      errors++;
      $display("FAIL timeout: observed=running expected=finished");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end
endmodule
